demux_gate_scheduler: RTL and testbench
=======================================

Name: demux_gate_scheduler

Overview:
- Shares one demux-built gate evaluator among NUM_REQ requesters.
- Evaluator computes AND / OR / NOT from 1x2 demux cells.
- Arbitrates requests round-robin, launches one operation per cycle, and returns results on a single tagged response channel with valid/ready backpressure.
- Sits between the small control masters and the demux gate datapath, so the datapath is instantiated once instead of per requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; must equal clog2(NUM_REQ).
- CNT_W, 16, width of the saturating completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  input  NUM_REQ  operand a, bit i belongs to requester i.
- req_b  input  NUM_REQ  operand b, bit i belongs to requester i.
- req_op  input  2*NUM_REQ  opcode, bits [2i+1:2i] belong to requester i. Encoding: 00 AND, 01 OR, 10 NOT a, 11 reserved.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer accept.
- rsp_id  output  ID_W  index of the requester the response belongs to.
- rsp_y  output  1  gate result.
- rsp_err  output  1  set when the opcode was 11.
- op_count  output  CNT_W  number of completed responses, saturating.

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - rsp_valid=0, rsp_id=0, rsp_y=0, rsp_err=0, op_count=0.
  - Round-robin pointer ptr=0.
  - req_ready must read all-zero while rst_n is low.
  - Any in-flight response is discarded; no partial transfer survives reset.
- Slot free: slot_free = !rsp_valid || rsp_ready.
- Arbitration (combinational, same cycle):
  - Only when slot_free, search req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - The first set bit is the grant; req_ready = one-hot grant.
  - If not slot_free, req_ready = 0.
  - A request is accepted in a cycle where req_valid[i] && req_ready[i].
- Pointer update: on accept of requester g, ptr <= (g+1) mod NUM_REQ. With NUM_REQ not a power of two, wrap explicitly. Otherwise ptr holds.
- Evaluation, for the granted requester's a, b:
  - AND: the demux with sel=a, i=b; take y1.
  - OR: y0|y1 of the demux with sel=a, i=b, OR-ed with a.
  - NOT: the demux with sel=a, i=1; take y0.
  - Opcode 11: y=0, err=1.
- Latency: accept in cycle N gives rsp_valid=1 in cycle N+1, with rsp_id=g and rsp_y/rsp_err registered.
- Back-to-back: accept in every cycle while rsp_ready=1, giving throughput of one operation per cycle.
- Backpressure: while rsp_valid && !rsp_ready, rsp_id, rsp_y and rsp_err hold stable and no new request is accepted.
- Simultaneous drain and accept (rsp_valid && rsp_ready and a new accept in the same cycle): the response register loads the new result and rsp_valid stays 1.
- Drain with no accept: rsp_valid <= 0.
- Counter: op_count increments on each rsp_valid && rsp_ready handshake and saturates at all-ones with no wrap.
- Fairness: a requester holding req_valid is granted within NUM_REQ accepts.
- Requester rules: a requester must keep req_valid and its operands stable until accepted. Changes before accept are not checked.

Decomposition:
- Shared package demux_gate_pkg holds:
  - Opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_NOT=2'b10, OP_RSVD=2'b11.
  - Typedef gate_op_t (2 bits).
- Sub-module gate_eval_demux (a, b, op → y, err) wraps three demux_1_2 instances plus the output mux. It is purely combinational and tested standalone.
- Arbiter, pointer, response register and counter live in demux_gate_scheduler.

Test Plan:
- Reset mid-stream: drive a request, then assert rst_n low during cycle N+1 → rsp_valid=0 immediately, ptr=0, op_count=0, req_ready=0000 while rst_n is low.
- Single request: requester 2 sends a=1, b=0, op=01 with rsp_ready=1 → req_ready=0100 in the accept cycle; next cycle rsp_valid=1, rsp_id=2, rsp_y=1, rsp_err=0.
- All four requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,… one per cycle; truth table checked for AND 1&1=1, OR 0|0=0, NOT 1=0.
- Backpressure: hold rsp_ready=0 for 3 cycles with a response pending → rsp_id/rsp_y stable, req_ready=0000; on release, the next grant follows the pointer. Then drain and accept in the same cycle → rsp_valid stays 1 with the new data.
- Reserved opcode: op=11 from requester 1 → rsp_err=1, rsp_y=0, and op_count still increments on handshake.
- Counter saturation with CNT_W=4: 20 handshakes → op_count=15.

Source files
------------

// File: rtl/demux_gate_pkg.sv
// Shared definitions for the demux-built gate evaluator and its scheduler.
// Contents:
//   gate_op_t  2-bit opcode type
//   OP_AND, OP_OR, OP_NOT, OP_RSVD  opcode encodings
package demux_gate_pkg;

  typedef logic [1:0] gate_op_t;

  localparam gate_op_t OP_AND  = 2'b00;
  localparam gate_op_t OP_OR   = 2'b01;
  localparam gate_op_t OP_NOT  = 2'b10;
  localparam gate_op_t OP_RSVD = 2'b11;

endpackage

// File: rtl/demux_gate_scheduler_gate_eval.sv
// Combinational gate evaluator built from 1x2 demux cells.
//
// demux_1_2 ports:
//   sel  select input
//   i    data input, routed to y0 when sel=0 and to y1 when sel=1
//   y0   i & ~sel
//   y1   i &  sel
//
// gate_eval_demux ports:
//   a, b  operands
//   op    opcode (AND / OR / NOT a / reserved)
//   y     gate result, 0 for the reserved opcode
//   err   set for the reserved opcode
module demux_1_2 (
  input  logic sel,
  input  logic i,
  output logic y0,
  output logic y1
);

  assign y0 = i & ~sel;
  assign y1 = i & sel;

endmodule

module gate_eval_demux
  import demux_gate_pkg::*;
(
  input  logic     a,
  input  logic     b,
  input  gate_op_t op,
  output logic     y,
  output logic     err
);

  logic and_y0, and_y1;
  logic or_y0, or_y1;
  logic not_y0, not_y1;
  logic unused_outs;

  // AND: b is routed to y1 only when a is high.
  demux_1_2 u_and (.sel(a), .i(b),    .y0(and_y0), .y1(and_y1));
  // OR: y0|y1 recovers b whatever a is; OR-ing a completes a|b.
  demux_1_2 u_or  (.sel(a), .i(b),    .y0(or_y0),  .y1(or_y1));
  // NOT: a constant 1 lands on y0 only when a is low.
  demux_1_2 u_not (.sel(a), .i(1'b1), .y0(not_y0), .y1(not_y1));

  // Leftover demux legs are not part of any gate function.
  assign unused_outs = &{1'b0, and_y0, not_y1};

  always_comb begin
    y   = 1'b0;
    err = 1'b0;
    case (op)
      OP_AND:  y = and_y1;
      OP_OR:   y = or_y0 | or_y1 | a;
      OP_NOT:  y = not_y0;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/demux_gate_scheduler.sv
// Shares one demux gate evaluator among NUM_REQ requesters. A round-robin
// arbiter grants one request per cycle whenever the single-entry response
// register is free or draining; the result is returned one cycle later on a
// tagged valid/ready response channel.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester request valid
//   req_ready    per-requester accept, one-hot or zero (zero during reset)
//   req_a/req_b  per-requester operand bits
//   req_op       per-requester 2-bit opcode, bits [2i+1:2i] for requester i
//   rsp_valid    response valid, rsp_ready its accept
//   rsp_id       requester index the response belongs to
//   rsp_y        gate result, rsp_err set for the reserved opcode
//   op_count     saturating count of completed response handshakes
module demux_gate_scheduler
  import demux_gate_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_a,
  input  logic [NUM_REQ-1:0]   req_b,
  input  logic [2*NUM_REQ-1:0] req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_y,
  output logic                 rsp_err,
  output logic [CNT_W-1:0]     op_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_y_q, rsp_y_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            slot_free;
  logic            found;
  logic            accept;
  logic [ID_W-1:0] grant_id;
  logic [ID_W:0]   cand_sum;
  logic [ID_W-1:0] cand;
  logic            sel_a, sel_b;
  gate_op_t        sel_op;
  logic            eval_y, eval_err;

  assign slot_free = !rsp_valid_q || rsp_ready;

  // Circular search from ptr_q; the extra sum bit keeps the wrap correct
  // when NUM_REQ is not a power of two.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand_sum >= (ID_W+1)'(NUM_REQ))
        cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
      cand = cand_sum[ID_W-1:0];
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  // rst_n gates the grant so req_ready reads zero for the whole reset.
  assign accept    = found && slot_free && rst_n;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;

  assign sel_a  = req_a[grant_id];
  assign sel_b  = req_b[grant_id];
  assign sel_op = req_op[{grant_id, 1'b0} +: 2];

  gate_eval_demux u_eval (
    .a   (sel_a),
    .b   (sel_b),
    .op  (sel_op),
    .y   (eval_y),
    .err (eval_err)
  );

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    if (accept) begin
      ptr_d       = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_id;
      rsp_y_d     = eval_y;
      rsp_err_d   = eval_err;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (rsp_valid_q && rsp_ready)
      cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_demux_gate_scheduler.sv
// Scoreboard bench for demux_gate_scheduler (NUM_REQ=4, CNT_W=4).
// The driver keeps a behavioural model of the requesters and the arbiter,
// pushes the expected response on every accept; a separate monitor compares
// whatever the DUT presents against the queue head.
module tb_demux_gate_scheduler;

  localparam int N   = 4;
  localparam int CW  = 4;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct {
    int id;
    bit y;
    bit err;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_a;
  logic [N-1:0]    req_b;
  logic [2*N-1:0]  req_op;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic            rsp_y;
  logic            rsp_err;
  logic [CW-1:0]   op_count;

  demux_gate_scheduler #(.NUM_REQ(N), .ID_W(2), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .op_count  (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  bit       pend [N];
  bit       ma   [N];
  bit       mb   [N];
  bit [1:0] mop  [N];
  int       mptr;
  int       mcnt;
  bit       acc_now;
  exp_t     exp_q[$];

  int n_tests;
  int n_fail;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_y(input bit a, input bit b, input bit [1:0] op);
    case (op)
      2'd0:    return a && b;
      2'd1:    return a || b;
      2'd2:    return !a;
      default: return 1'b0;
    endcase
  endfunction

  // One clock of stimulus: new requests appear with probability vprob%,
  // rsp_ready is high with probability rprob%; opmode<0 picks random ops.
  task automatic step(input int vprob, input int rprob, input int opmode);
    int g;
    bit sf;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && ($urandom_range(99) < vprob)) begin
        pend[i] = 1'b1;
        ma[i]   = 1'($urandom);
        mb[i]   = 1'($urandom);
        mop[i]  = (opmode < 0) ? 2'($urandom) : 2'(opmode);
      end
    end
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pend[i];
      req_a[i]           = ma[i];
      req_b[i]           = mb[i];
      req_op[2*i +: 2]   = mop[i];
    end
    rsp_ready = ($urandom_range(99) < rprob);
    #1;
    sf = (exp_q.size() == 0) || rsp_ready;
    g  = -1;
    if (sf)
      for (int k = 0; k < N; k++)
        if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    acc_now = (g >= 0);
    if (g >= 0) begin
      exp_q.push_back('{g, model_y(ma[g], mb[g], mop[g]), mop[g] == 2'b11});
      pend[g] = 1'b0;
      mptr    = (g + 1) % N;
    end
  endtask

  task automatic preset(input int i, input bit a, input bit b, input bit [1:0] op);
    pend[i] = 1'b1;
    ma[i]   = a;
    mb[i]   = b;
    mop[i]  = op;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    mptr    = 0;
    mcnt    = 0;
    acc_now = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id",    32'(rsp_id),    0);
    check("rst_rsp_y",     32'(rsp_y),     0);
    check("rst_rsp_err",   32'(rsp_err),   0);
    check("rst_op_count",  32'(op_count),  0);
    check("rst_req_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    check("rst_req_ready_hold", 32'(req_ready), 0);
    check("rst_rsp_valid_hold", 32'(rsp_valid), 0);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b1;
  endtask

  // Monitor: compares the presented response with the queue head every
  // cycle it is valid (so held data under backpressure is checked too),
  // and retires the head on handshake.
  initial begin
    int outst;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        outst = exp_q.size() - int'(acc_now);
        check("rsp_valid", 32'(rsp_valid), 32'(outst > 0));
        check("op_count",  32'(op_count),  32'(mcnt));
        if (rsp_valid && outst > 0) begin
          check("rsp_id",  32'(rsp_id),  32'(exp_q[0].id));
          check("rsp_y",   32'(rsp_y),   32'(exp_q[0].y));
          check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            mcnt = (mcnt == MAXC) ? MAXC : mcnt + 1;
          end
        end
      end
    end
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    acc_now   = 1'b0;
    mptr      = 0;
    mcnt      = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; ma[i] = 1'b0; mb[i] = 1'b0; mop[i] = 2'b00;
    end
    do_reset();

    // All four valid continuously: round robin 0,1,2,3,... with a truth-table seed
    preset(0, 1'b1, 1'b1, 2'b00);
    preset(1, 1'b0, 1'b0, 2'b01);
    preset(2, 1'b1, 1'b0, 2'b10);
    preset(3, 1'b0, 1'b1, 2'b01);
    for (int c = 0; c < 12; c++) step(100, 100, -1);
    for (int c = 0; c < 6; c++) step(0, 100, -1);

    // Single request from requester 2: OR of 1,0
    preset(2, 1'b1, 1'b0, 2'b01);
    step(0, 100, -1);
    step(0, 100, -1);
    step(0, 100, -1);

    // Backpressure for 3 cycles, then release with drain+accept
    step(100, 100, -1);
    for (int c = 0; c < 3; c++) step(100, 0, -1);
    for (int c = 0; c < 4; c++) step(100, 100, -1);
    for (int c = 0; c < 6; c++) step(0, 100, -1);

    // Reserved opcode from requester 1
    preset(1, 1'b1, 1'b1, 2'b11);
    step(0, 100, -1);
    step(0, 100, -1);
    step(0, 100, -1);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 300; c++) step(40, 70, -1);
    for (int c = 0; c < 8; c++) step(0, 100, -1);

    // Reset mid-stream: accept, then reset while the response is pending
    preset(0, 1'b1, 1'b1, 2'b00);
    step(0, 100, -1);
    do_reset();

    // Saturation: well over 15 handshakes
    for (int c = 0; c < 22; c++) step(100, 100, -1);
    for (int c = 0; c < 8; c++) step(0, 100, -1);
    @(negedge clk);
    #1;
    check("op_count_sat", 32'(op_count), 32'(MAXC));
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
